// File: rtl/ysyx_22040210_pht_sat.sv
// Gshare pattern history table of saturating counters with RD_PORTS registered lookup ports,
// one read-modify-write update per cycle and a self-initialising sweep. Option: YSYX_22040210_PHT_BYPASS_EN.
module ysyx_22040210_pht_sat #(
    parameter int IDX_W    = 8,
    parameter int CNT_W    = 2,
    parameter int RD_PORTS = 2,
    parameter int INIT_CNT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [RD_PORTS-1:0]       rd_en,
    input  logic [RD_PORTS*IDX_W-1:0] rd_idx,
    output logic [RD_PORTS*CNT_W-1:0] rd_cnt,
    output logic [RD_PORTS-1:0]       rd_taken,
    output logic [RD_PORTS-1:0]       rd_valid,
    input  logic                      upd_valid,
    input  logic [IDX_W-1:0]          upd_idx,
    input  logic                      upd_taken,
    output logic                      upd_ready,
    output logic                      init_busy
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_CNT);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] table_q [DEPTH];

    logic             upd_acc;
    logic [CNT_W-1:0] upd_old;
    logic [CNT_W-1:0] upd_new;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] wr_cnt;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) begin
                state_d = ST_RUN;
            end
        end
        if (flush) begin
            state_d = ST_INIT;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign init_busy = (state_q == ST_INIT);
    assign upd_ready = (state_q == ST_RUN);

    // A flush in the same cycle wins over the update, so the update is never accepted.
    assign upd_acc = (state_q == ST_RUN) && upd_valid && !flush;
    assign upd_old = table_q[upd_idx];

    always_comb begin
        upd_new = upd_old;
        if (upd_taken && (upd_old != CNT_MAX)) begin
            upd_new = upd_old + 1'b1;
        end else if (!upd_taken && (upd_old != CNT_ZERO)) begin
            upd_new = upd_old - 1'b1;
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = upd_idx;
        wr_cnt = upd_new;
        if (state_q == ST_INIT) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            wr_cnt = INIT_VAL;
        end else if (upd_acc) begin
            wr_en = 1'b1;
        end
    end

    // Table storage is deliberately unreset; the sweep defines every entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_idx] <= wr_cnt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_PORTS; gi++) begin : g_port
            logic [IDX_W-1:0] idx;
            logic [CNT_W-1:0] look;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             valid_q, valid_d;

            assign idx = rd_idx[gi*IDX_W +: IDX_W];
`ifdef YSYX_22040210_PHT_BYPASS_EN
            assign look = (upd_acc && (idx == upd_idx)) ? upd_new : table_q[idx];
`else
            assign look = table_q[idx];
`endif

            always_comb begin
                cnt_d   = cnt_q;
                valid_d = 1'b0;
                if (rd_en[gi] && (state_q == ST_RUN)) begin
                    cnt_d   = look;
                    valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    valid_q <= valid_d;
                end
            end

            assign rd_cnt[gi*CNT_W +: CNT_W] = cnt_q;
            assign rd_taken[gi]              = cnt_q[CNT_W-1];
            assign rd_valid[gi]              = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_ysyx_22040210_pht_sat.sv
// Scoreboard bench for ysyx_22040210_pht_sat: lookups push expected counters, a negedge monitor pops on rd_valid.
module tb_ysyx_22040210_pht_sat;
    localparam int IDX_W = 8;
    localparam int CNT_W = 2;
    localparam int RD_PORTS = 2;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic [RD_PORTS-1:0]       rd_en;
    logic [RD_PORTS*IDX_W-1:0] rd_idx;
    logic [RD_PORTS*CNT_W-1:0] rd_cnt;
    logic [RD_PORTS-1:0]       rd_taken;
    logic [RD_PORTS-1:0]       rd_valid;
    logic                      upd_valid;
    logic [IDX_W-1:0]          upd_idx;
    logic                      upd_taken;
    logic                      upd_ready;
    logic                      init_busy;

    int checks = 0;
    int failures = 0;
    int exp_q0[$];
    int exp_q1[$];

    ysyx_22040210_pht_sat #(
        .IDX_W(IDX_W), .CNT_W(CNT_W), .RD_PORTS(RD_PORTS), .INIT_CNT(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_cnt(rd_cnt),
        .rd_taken(rd_taken), .rd_valid(rd_valid),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .init_busy(init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every valid lookup response must match the oldest expectation of its port.
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < RD_PORTS; p++) begin
                if (rd_valid[p]) begin
                    int e;
                    int a;
                    a = int'(rd_cnt[p*CNT_W +: CNT_W]);
                    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                        check($sformatf("unexpected_valid_p%0d", p), 1, 0);
                    end else begin
                        e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        $display("lookup p%0d cnt=%0d taken=%0d exp_cnt=%0d", p, a, rd_taken[p], e);
                        check($sformatf("rd_cnt_p%0d", p), a, e);
                        check($sformatf("rd_taken_p%0d", p), int'(rd_taken[p]), (e >= 2) ? 1 : 0);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; expected responses are queued only for lookups issued in RUN.
    task automatic step(input bit fl, input bit uv, input logic [7:0] ui, input bit ut,
                        input bit e0, input logic [7:0] i0, input int x0,
                        input bit e1, input logic [7:0] i1, input int x1);
        flush = fl;
        upd_valid = uv;
        upd_idx = ui;
        upd_taken = ut;
        rd_en = {e1, e0};
        rd_idx = {i1, i0};
        if (e0) exp_q0.push_back(x0);
        if (e1) exp_q1.push_back(x1);
        tick();
        flush = 1'b0;
        upd_valid = 1'b0;
        rd_en = '0;
    endtask

    task automatic upd(input logic [7:0] ui, input bit ut);
        step(0, 1, ui, ut, 0, 8'h00, 0, 0, 8'h00, 0);
    endtask

    task automatic look(input logic [7:0] i0, input int x0, input logic [7:0] i1, input int x1);
        step(0, 0, 8'h00, 0, 1, i0, x0, 1, i1, x1);
    endtask

    task automatic wait_sweep(input string name);
        int n;
        n = 0;
        while (init_busy && n < 1000) begin
            tick();
            n++;
        end
        $display("sweep %s cycles=%0d", name, n);
        check(name, n, 256);
    endtask

    initial begin
        int exp_byp;
        rst = 1'b1;
        flush = 1'b0;
        rd_en = '0;
        rd_idx = '0;
        upd_valid = 1'b0;
        upd_idx = '0;
        upd_taken = 1'b0;
        #2;
        check("rst_rd_cnt", int'(rd_cnt), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_upd_ready", int'(upd_ready), 0);
        check("rst_init_busy", int'(init_busy), 1);
        repeat (2) @(posedge clk);
        #1;
        // Lookups and updates during the sweep must be ignored / dropped.
        rd_en = 2'b11;
        rd_idx = {8'h2A, 8'h2A};
        upd_valid = 1'b1;
        upd_idx = 8'h2A;
        upd_taken = 1'b1;
        rst = 1'b0;
        wait_sweep("sweep_after_rst");
        rd_en = '0;
        upd_valid = 1'b0;
        check("run_upd_ready", int'(upd_ready), 1);

        look(8'h00, 1, 8'hFF, 1);

        upd(8'h2A, 1); look(8'h2A, 2, 8'h00, 1);
        upd(8'h2A, 1); look(8'h2A, 3, 8'h00, 1);
        upd(8'h2A, 1); look(8'h2A, 3, 8'h00, 1);
        upd(8'h40, 1); upd(8'h40, 1); upd(8'h40, 1);
        look(8'h2A, 3, 8'h40, 3);

        upd(8'h2A, 0); look(8'h2A, 2, 8'h40, 3);
        upd(8'h2A, 0); look(8'h2A, 1, 8'h40, 3);
        upd(8'h2A, 0); look(8'h2A, 0, 8'h40, 3);
        upd(8'h2A, 0); look(8'h2A, 0, 8'h40, 3);

`ifdef YSYX_22040210_PHT_BYPASS_EN
        exp_byp = 2;
`else
        exp_byp = 1;
`endif
        step(0, 1, 8'h10, 1, 1, 8'h10, exp_byp, 1, 8'h11, 1);
        look(8'h10, 2, 8'h11, 1);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        check("hold_rd_cnt_p0", int'(rd_cnt[1:0]), 2);
        check("hold_rd_cnt_p1", int'(rd_cnt[3:2]), 1);
        check("idle_rd_valid", int'(rd_valid), 0);

        step(1, 1, 8'h10, 1, 0, 8'h00, 0, 0, 8'h00, 0);
        check("flush_init_busy", int'(init_busy), 1);
        check("flush_upd_ready", int'(upd_ready), 0);
        rd_en = 2'b11;
        rd_idx = {8'h10, 8'h10};
        wait_sweep("sweep_after_flush");
        rd_en = '0;
        look(8'h10, 1, 8'h2A, 1);
        look(8'h40, 1, 8'h11, 1);

        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        repeat (100) tick();
        rst = 1'b1;
        #1;
        check("async_rst_rd_cnt", int'(rd_cnt), 0);
        check("async_rst_rd_valid", int'(rd_valid), 0);
        check("async_rst_upd_ready", int'(upd_ready), 0);
        check("async_rst_init_busy", int'(init_busy), 1);
        repeat (2) tick();
        rst = 1'b0;
        wait_sweep("sweep_after_async_rst");
        look(8'h00, 1, 8'hFF, 1);
        look(8'h40, 1, 8'h2A, 1);

        repeat (3) tick();
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
